// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, delayed-branch redirect handling and the IF/ID register.
// A redirect that resolves during a fetch wait is parked in PEND until the delay slot arrives.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        IM_Ready,
    input  logic [31:0] Instr_F,
    input  logic        Branch_D,
    input  logic        CMPrst,
    input  logic        Jump_D,
    input  logic        JumpReg_D,
    input  logic [31:0] RegV1_D,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        Valid_D,
    output logic        AdEL_D
);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc8_d;
    logic        r_valid_d;
    logic        r_adel_d;
    logic [31:0] r_pend_tgt;

    logic        w_redir;
    logic        w_fetch;
    logic [31:0] w_target;
    logic [31:0] w_br_off;
    logic [31:0] w_pc_nxt;

    assign w_redir  = r_valid_d & ~Stall & ((Branch_D & CMPrst) | Jump_D | JumpReg_D);
    assign w_fetch  = IM_Ready & ~Stall;
    assign w_br_off = {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};

    always_comb begin
        w_target = r_pc_d + 32'd4 + w_br_off;
        if (JumpReg_D)
            w_target = RegV1_D;
        else if (Jump_D)
            w_target = {r_pc_d[31:28], r_instr_d[25:0], 2'b00};
    end

    always_comb begin
        w_pc_nxt = r_pc + 32'd4;
        if (w_redir)
            w_pc_nxt = w_target;
        else if (r_state == S_PEND)
            w_pc_nxt = r_pend_tgt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_fetch)
            w_state_nxt = S_IDLE;
        else if (!Stall && w_redir)
            w_state_nxt = S_PEND;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Stall freezes everything; a fetch wait only injects a bubble and may park a target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr_d  <= 32'd0;
            r_pc_d     <= 32'd0;
            r_pc8_d    <= 32'd0;
            r_valid_d  <= 1'b0;
            r_adel_d   <= 1'b0;
            r_pend_tgt <= 32'd0;
        end else if (!Stall) begin
            if (IM_Ready) begin
                r_instr_d <= Instr_F;
                r_pc_d    <= r_pc;
                r_pc8_d   <= r_pc + 32'd8;
                r_valid_d <= 1'b1;
                r_adel_d  <= (r_pc[1:0] != 2'b00);
                r_pc      <= w_pc_nxt;
            end else begin
                r_instr_d <= 32'd0;
                r_valid_d <= 1'b0;
                r_adel_d  <= 1'b0;
                if (w_redir)
                    r_pend_tgt <= w_target;
            end
        end
    end

    assign PC_F    = r_pc;
    assign Instr_D = r_instr_d;
    assign PC_D    = r_pc_d;
    assign PC8_D   = r_pc8_d;
    assign Valid_D = r_valid_d;
    assign AdEL_D  = r_adel_d;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC: default 32'h00003000; the PC_F value after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; takes effect on the rising edge of clk while high.
REQ-004 Stall  input  1  from the hazard unit; freezes PC_F and the IF/ID register.
REQ-005 IM_Ready  input  1  instruction memory has valid data for PC_F this cycle.
REQ-006 Instr_F  input  32  instruction word returned for PC_F.
REQ-007 Branch_D  input  1  decoded instruction in D is a conditional branch.
REQ-008 CMPrst  input  1  branch condition result for the instruction in D (1 = taken).
REQ-009 Jump_D  input  1  instruction in D is j or jal.
REQ-010 JumpReg_D  input  1  instruction in D is jr or jalr.
REQ-011 RegV1_D  input  32  forwarded rs value in D (jump-register target).
REQ-012 PC_F  output  32  fetch address to instruction memory.
REQ-013 Instr_D / PC_D / PC8_D  output  32 each  IF/ID contents; PC8_D = PC_D + 8.
REQ-014 Valid_D  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 AdEL_D  output  1  instruction in D was fetched from a PC with PC[1:0] != 0.

Function
REQ-016 Redirect: redir_now = Valid_D & ~Stall & ((Branch_D & CMPrst) | Jump_D | JumpReg_D).
REQ-017 Target priority: JumpReg_D -> RegV1_D; Jump_D -> {PC_D[31:28], Instr_D[25:0], 2'b00}; branch -> PC_D + 4 + (sign-extend(Instr_D[15:0]) << 2); all in 32-bit wrap-around arithmetic.
REQ-018 A completed fetch occurs when IM_Ready & ~Stall.
REQ-019 On a completed fetch: IF/ID <= {Instr_F, PC_F, PC_F+8, Valid 1, AdEL = (PC_F[1:0] != 0)}.
REQ-020 Next PC on a completed fetch: redir_now -> target; else state PEND -> pend_target; else PC_F + 4; the 32-bit increment wraps 32'hFFFFFFFC -> 0.
REQ-021 Delay-slot semantics: the instruction fetched in the cycle a redirect resolves is always kept; there is no flush.
REQ-022 IM_Ready=0 with Stall=0 (fetch wait):
- PC_F holds.
- IF/ID loads a bubble: Instr_D=0, Valid_D=0, AdEL_D=0, PC_D/PC8_D hold.
- If redir_now, pend_target <= target and the state goes to PEND.
REQ-023 Stall=1:
- PC_F, IF/ID, state and pend_target all hold, whatever IM_Ready is.
- Instr_F is discarded and refetched later.
- redir_now is 0.
REQ-024 FSM states:
- IDLE -> PEND on REQ-022 with a redirect.
- PEND -> IDLE on a completed fetch, which consumes pend_target.
- All other cases hold the state.
REQ-025 In PEND, Valid_D is 0 until the delay slot arrives, so no second redirect is captured; a control transfer in a delay slot is undefined by the ISA and need not be handled.
REQ-026 AdEL_D is a flag only; fetch continues sequentially.

Reset
REQ-027 On reset:
- PC_F = RESET_PC.
- Instr_D = 0, PC_D = 0, PC8_D = 0, Valid_D = 0, AdEL_D = 0.
- State IDLE, pend_target = 0.
REQ-028 Reset overrides Stall, IM_Ready and any redirect in the same cycle; a pending redirect is discarded.

Verification
REQ-029 Reset, then IM_Ready=1 and Stall=0 for 3 cycles -> PC_F = 3000, 3004, 3008, 300C; PC_D = 3000 with PC8_D = 3008 one cycle after the first fetch.
REQ-030 beq at 3000 in D, taken, imm16 = 0x0004 -> delay slot 3004 enters D; the next PC_F = 3014.
REQ-031 jr in D with RegV1_D = 0x00004000 and IM_Ready=0 for 2 cycles -> state PEND and PC_F holds 3004 while waiting; Valid_D=0 bubbles; when IM_Ready returns, 3004 enters D and the next PC_F = 4000.
REQ-032 Stall=1 for 2 cycles while j (target 0x00003100) is in D -> PC_F and IF/ID unchanged; on the first unstalled cycle the delay slot enters D and PC_F = 3100.
REQ-033 jr with RegV1_D = 0x00003002 -> the fetch at 3002 yields AdEL_D = 1 in D; PC_F continues to 3006.
REQ-034 Reset asserted while in PEND with pend_target = 5000 -> PC_F = 3000 and state IDLE; the subsequent fetches never reach 5000.
